// File: rtl/ds18b20_responder.sv
// ds18b20_responder: behaves as a single DS18B20 on a 1-Wire bus.
// Handles reset/presence, Skip ROM, Convert T and Read Scratchpad with CRC8.
`timescale 1ns/1ps
module ds18b20_responder #(
   parameter int CLK_HZ = 12_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dq_in,
   input  logic [15:0] temp_in,
   output logic        dq_oe,
   output logic        conv_pulse
);

   localparam int TICK = CLK_HZ / 1_000_000;
   localparam int PW = $clog2(TICK);
   // one tick of slack absorbs synchronizer skew between fall and rise
   localparam logic [9:0] RST_US = 10'd479;

   typedef enum logic [3:0] {
      IDLE, RST_WAIT, PRES_DLY, PRESENCE, ROM_CMD,
      FN_CMD, TX_SCRATCH, CONV_RD, HALT
   } state_t;

   state_t state, state_nx;

   logic          dq_s1, dq_s2, dq_d;
   logic          fall, rise, tick, rst_end;
   logic          slot_st, clr_slot, clr_pre;
   logic [PW-1:0] pre;
   logic [9:0]    low_us, slot_us;
   logic          wr_busy, sample, byte_done;
   logic          drv, cur_bit, conv_q, crc_fb;
   logic [7:0]    sr, new_byte, crc, crc_next, cur_byte;
   logic [2:0]    bit_cnt;
   logic [6:0]    bit_idx;
   logic [15:0]   temp_q;

   assign fall = dq_d & ~dq_s2;
   assign rise = ~dq_d & dq_s2;
   assign tick = (pre == PW'(TICK - 1));
   assign rst_end = rise & (low_us >= RST_US);
   assign slot_st = (state == ROM_CMD) | (state == FN_CMD) |
                    (state == TX_SCRATCH) | (state == CONV_RD);
   assign clr_slot = rst_end | (fall & slot_st) |
                     ((state == PRES_DLY) & (slot_us == 10'd30));
   // our own presence drive must not disturb the µs phase
   assign clr_pre = clr_slot | (fall & ~dq_oe);
   assign sample = wr_busy & (slot_us == 10'd30);
   assign new_byte = {dq_s2, sr[7:1]};
   assign byte_done = sample & (bit_cnt == 3'd7);

   assign crc_fb = crc[0] ^ cur_bit;
   assign crc_next = {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);

   always_comb begin
      unique case (bit_idx[6:3])
         4'd0:    cur_byte = temp_q[7:0];
         4'd1:    cur_byte = temp_q[15:8];
         4'd2:    cur_byte = 8'h4B;
         4'd3:    cur_byte = 8'h46;
         4'd4:    cur_byte = 8'h7F;
         4'd5:    cur_byte = 8'hFF;
         4'd6:    cur_byte = 8'h0C;
         4'd7:    cur_byte = 8'h10;
         default: cur_byte = crc;
      endcase
   end

   assign cur_bit = cur_byte[bit_idx[2:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dq_s1   <= 1'b1;
         dq_s2   <= 1'b1;
         dq_d    <= 1'b1;
         pre     <= '0;
         low_us  <= '0;
         slot_us <= '0;
      end else begin
         dq_s1 <= dq_in;
         dq_s2 <= dq_s1;
         dq_d  <= dq_s2;
         if (clr_pre || tick) pre <= '0;
         else pre <= pre + 1'b1;
         if (dq_s2) low_us <= '0;
         else if (tick && low_us != '1) low_us <= low_us + 1'b1;
         if (clr_slot) slot_us <= '0;
         else if (tick && slot_us != '1) slot_us <= slot_us + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_busy <= 1'b0;
         sr      <= '0;
         bit_cnt <= '0;
         bit_idx <= '0;
         crc     <= '0;
         drv     <= 1'b0;
         conv_q  <= 1'b0;
         temp_q  <= 16'h0550;
      end else begin
         conv_q <= 1'b0;
         if (rst_end) begin
            wr_busy <= 1'b0;
            sr      <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            crc     <= '0;
            drv     <= 1'b0;
         end else begin
            if (fall && (state == ROM_CMD || state == FN_CMD)) begin
               wr_busy <= 1'b1;
            end else if (sample) begin
               wr_busy <= 1'b0;
               sr      <= new_byte;
               bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall && state == TX_SCRATCH) begin
               drv     <= ~cur_bit;
               bit_idx <= bit_idx + 1'b1;
               if (bit_idx < 7'd64) crc <= crc_next;
            end else if (slot_us == 10'd30) begin
               drv <= 1'b0;
            end
            if (byte_done && state == FN_CMD && new_byte == 8'h44) begin
               conv_q <= 1'b1;
               temp_q <= temp_in;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (rst_end) begin
         state_nx = PRES_DLY;
      end else begin
         unique case (state)
            IDLE, HALT: if (fall) state_nx = RST_WAIT;
            RST_WAIT:   if (rise) state_nx = IDLE;
            PRES_DLY:   if (slot_us == 10'd30) state_nx = PRESENCE;
            PRESENCE:   if (slot_us == 10'd120) state_nx = ROM_CMD;
            ROM_CMD: begin
               if (byte_done)
                  state_nx = (new_byte == 8'hCC) ? FN_CMD : HALT;
            end
            FN_CMD: begin
               if (byte_done) begin
                  unique case (1'b1)
                     new_byte == 8'h44: state_nx = CONV_RD;
                     new_byte == 8'hBE: state_nx = TX_SCRATCH;
                     default:           state_nx = HALT;
                  endcase
               end
            end
            TX_SCRATCH: if (fall && bit_idx == 7'd71) state_nx = HALT;
            CONV_RD:    state_nx = CONV_RD;
            default:    state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      dq_oe      = (state == PRESENCE) | drv;
      conv_pulse = conv_q;
   end

endmodule

// File: tb/tb_ds18b20_responder.sv
// tb_ds18b20_responder: directed 1-Wire master driving the responder.
// Main instance at 2 MHz; 12/48 MHz instances compare presence timing.
`timescale 1ns/1ps
module tb_ds18b20_responder;

   logic clk_a = 1'b0, clk_b = 1'b0, clk_c = 1'b0;
   logic rst_n = 1'b1, rst_n_sw = 1'b1;
   logic sw_en = 1'b0;
   logic master_low = 1'b0;
   logic [15:0] temp_in = 16'h0000;
   logic oe_a, oe_b, oe_c;
   logic conv_a, conv_b, conv_c;
   logic bus_a, bus_b, bus_c;
   int n_checks = 0;
   int n_fail = 0;
   int conv_cnt = 0;
   int oe_cnt = 0;

   assign bus_a = ~(master_low | oe_a);
   assign bus_b = ~(master_low | oe_b);
   assign bus_c = ~(master_low | oe_c);

   always #250 clk_a = ~clk_a;
   always #41.667 if (sw_en) clk_b = ~clk_b;
   always #10.417 if (sw_en) clk_c = ~clk_c;

   always @(negedge clk_a) begin
      if (conv_a) conv_cnt++;
      if (oe_a) oe_cnt++;
   end

   ds18b20_responder #(.CLK_HZ(2_000_000)) u_dut (
      .clk(clk_a), .rst_n(rst_n), .dq_in(bus_a), .temp_in(temp_in),
      .dq_oe(oe_a), .conv_pulse(conv_a));

   ds18b20_responder #(.CLK_HZ(12_000_000)) u_dut12 (
      .clk(clk_b), .rst_n(rst_n_sw), .dq_in(bus_b), .temp_in(temp_in),
      .dq_oe(oe_b), .conv_pulse(conv_b));

   ds18b20_responder #(.CLK_HZ(48_000_000)) u_dut48 (
      .clk(clk_c), .rst_n(rst_n_sw), .dq_in(bus_c), .temp_in(temp_in),
      .dq_oe(oe_c), .conv_pulse(conv_c));

   function automatic logic [7:0] crc8(input logic [63:0] d);
      logic [7:0] c;
      logic fb;
      c = 8'h00;
      for (int i = 0; i < 64; i++) begin
         fb = c[0] ^ d[i];
         c = c >> 1;
         if (fb) c = c ^ 8'h8C;
      end
      return c;
   endfunction

   task automatic bus_reset(input int low_us, output int rise_ns, output int width_ns);
      int t;
      master_low = 1'b1;
      #(low_us * 1000);
      master_low = 1'b0;
      rise_ns = -1;
      width_ns = -1;
      t = 0;
      while (!oe_a && t < 200_000) begin #100; t += 100; end
      if (oe_a) begin
         rise_ns = t;
         t = 0;
         while (oe_a && t < 200_000) begin #100; t += 100; end
         if (!oe_a) width_ns = t;
      end
      #5000;
   endtask

   task automatic write_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         master_low = 1'b1;
         if (v[i]) begin #3000; master_low = 1'b0; #37000; end
         else begin #35000; master_low = 1'b0; #5000; end
      end
   endtask

   task automatic read_bit(output logic b);
      master_low = 1'b1;
      #2000;
      master_low = 1'b0;
      #13000;
      b = bus_a;
      #25000;
   endtask

   task automatic read_byte(output logic [7:0] v);
      logic b;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         v[i] = b;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      rst_n_sw = 1'b1;
      #10;
      rst_n = 1'b0;
      rst_n_sw = 1'b0;
      #1000;
      n_checks++;
      if (oe_a !== 1'b0) begin
         n_fail++; $display("FAIL rst_oe: got %b expected 0", oe_a);
      end
      n_checks++;
      if (conv_a !== 1'b0) begin
         n_fail++; $display("FAIL rst_conv: got %b expected 0", conv_a);
      end
      n_checks++;
      if ({oe_b, oe_c} !== 2'b00) begin
         n_fail++; $display("FAIL rst_oe_sweep: got %b expected 00", {oe_b, oe_c});
      end
      rst_n = 1'b1;
      #5000;
   endtask

   task automatic test_skip_read();
      int r, w;
      logic [71:0] sp;
      logic [7:0] v;
      logic b;
      sp = 72'h1C_10_0C_FF_7F_46_4B_05_50;
      bus_reset(480, r, w);
      n_checks++;
      if (r < 30000 || r > 33000) begin
         n_fail++; $display("FAIL pres_delay: got %0d ns expected 30000..33000", r);
      end
      n_checks++;
      if (w < 119000 || w > 122000) begin
         n_fail++; $display("FAIL pres_width: got %0d ns expected 119000..122000", w);
      end
      write_byte(8'hCC);
      write_byte(8'hBE);
      for (int i = 0; i < 9; i++) begin
         read_byte(v);
         n_checks++;
         if (v !== sp[8*i +: 8]) begin
            n_fail++;
            $display("FAIL scratch_byte%0d: got %h expected %h", i, v, sp[8*i +: 8]);
         end
      end
      read_bit(b);
      n_checks++;
      if (b !== 1'b1) begin
         n_fail++; $display("FAIL read_after_72: got %b expected 1", b);
      end
   endtask

   task automatic test_convert();
      int r, w, base;
      logic [3:0] nib;
      logic [7:0] v, e;
      logic [63:0] d;
      logic b;
      temp_in = 16'hFF5E;
      bus_reset(480, r, w);
      n_checks++;
      if (r < 30000 || r > 33000) begin
         n_fail++; $display("FAIL cv_presence: got %0d ns expected 30000..33000", r);
      end
      base = conv_cnt;
      write_byte(8'hCC);
      write_byte(8'h44);
      #2000;
      temp_in = 16'h1234;
      n_checks++;
      if (conv_cnt - base != 1) begin
         n_fail++; $display("FAIL conv_pulse_cycles: got %0d expected 1", conv_cnt - base);
      end
      for (int i = 0; i < 4; i++) begin
         read_bit(b);
         nib[i] = b;
      end
      n_checks++;
      if (nib !== 4'hF) begin
         n_fail++; $display("FAIL conv_rd_slots: got %h expected f", nib);
      end
      bus_reset(480, r, w);
      write_byte(8'hCC);
      write_byte(8'hBE);
      d = 64'h10_0C_FF_7F_46_4B_FF_5E;
      for (int i = 0; i < 9; i++) begin
         e = (i < 8) ? d[8*i +: 8] : crc8(d);
         read_byte(v);
         n_checks++;
         if (v !== e) begin
            n_fail++; $display("FAIL cv_byte%0d: got %h expected %h", i, v, e);
         end
      end
   endtask

   task automatic test_unknown();
      int r, w, base;
      logic [7:0] v;
      bus_reset(480, r, w);
      n_checks++;
      if (r < 30000 || r > 33000) begin
         n_fail++; $display("FAIL unk_presence: got %0d ns expected 30000..33000", r);
      end
      write_byte(8'h55);
      base = oe_cnt;
      read_byte(v);
      n_checks++;
      if (v !== 8'hFF) begin
         n_fail++; $display("FAIL halt_read: got %h expected ff", v);
      end
      n_checks++;
      if (oe_cnt != base) begin
         n_fail++; $display("FAIL halt_no_drive: got %0d oe samples expected 0", oe_cnt - base);
      end
      bus_reset(480, r, w);
      n_checks++;
      if (r < 30000 || r > 33000) begin
         n_fail++; $display("FAIL halt_presence: got %0d ns expected 30000..33000", r);
      end
   endtask

   task automatic test_mid_read();
      int r, w;
      logic [19:0] mid, got;
      logic [7:0] v;
      logic b;
      mid = 20'hBFF5E;
      got = '0;
      bus_reset(480, r, w);
      write_byte(8'hCC);
      write_byte(8'hBE);
      master_low = 1'b1;
      #1600;
      n_checks++;
      if (oe_a !== 1'b1) begin
         n_fail++; $display("FAIL rd_oe_rise: got %b expected 1", oe_a);
      end
      #38400;
      n_checks++;
      if (oe_a !== 1'b0) begin
         n_fail++; $display("FAIL rd_no_stretch: got %b expected 0", oe_a);
      end
      #10000;
      master_low = 1'b0;
      #10000;
      for (int i = 1; i < 20; i++) begin
         read_bit(b);
         got[i] = b;
      end
      n_checks++;
      if (got[19:1] !== mid[19:1]) begin
         n_fail++; $display("FAIL mid_bits: got %h expected %h", got[19:1], mid[19:1]);
      end
      bus_reset(500, r, w);
      n_checks++;
      if (r < 30000 || r > 33000 || w < 119000 || w > 122000) begin
         n_fail++;
         $display("FAIL mid_presence: got %0d/%0d ns expected 30000..33000/119000..122000", r, w);
      end
      write_byte(8'hCC);
      write_byte(8'hBE);
      read_byte(v);
      n_checks++;
      if (v !== 8'h5E) begin
         n_fail++; $display("FAIL restart_byte0: got %h expected 5e", v);
      end
      read_byte(v);
      n_checks++;
      if (v !== 8'hFF) begin
         n_fail++; $display("FAIL restart_byte1: got %h expected ff", v);
      end
   endtask

   task automatic test_short_low();
      int r, w;
      rst_n = 1'b0;
      #1000;
      rst_n = 1'b1;
      #5000;
      bus_reset(300, r, w);
      n_checks++;
      if (r != -1) begin
         n_fail++; $display("FAIL short_low: got presence at %0d ns expected none", r);
      end
      master_low = 1'b1;
      #480000;
      master_low = 1'b0;
      #100000;
      n_checks++;
      if (oe_a !== 1'b1) begin
         n_fail++; $display("FAIL pres_before_rst: got %b expected 1", oe_a);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (oe_a !== 1'b0) begin
         n_fail++; $display("FAIL rst_async_release: got %b expected 0", oe_a);
      end
      #2000;
      rst_n = 1'b1;
      #5000;
   endtask

   task automatic test_sweep();
      int rb, rc, fb, fc;
      rb = -1; rc = -1; fb = -1; fc = -1;
      rst_n_sw = 1'b1;
      sw_en = 1'b1;
      #2000;
      master_low = 1'b1;
      #480000;
      master_low = 1'b0;
      for (int t = 0; t <= 200000; t += 100) begin
         if (rb < 0 && oe_b) rb = t;
         if (rc < 0 && oe_c) rc = t;
         if (rb >= 0 && fb < 0 && !oe_b) fb = t;
         if (rc >= 0 && fc < 0 && !oe_c) fc = t;
         #100;
      end
      n_checks++;
      if (rb < 30000 || rb > 31500) begin
         n_fail++; $display("FAIL sweep12_delay: got %0d ns expected 30000..31500", rb);
      end
      n_checks++;
      if (rc < 30000 || rc > 31500) begin
         n_fail++; $display("FAIL sweep48_delay: got %0d ns expected 30000..31500", rc);
      end
      n_checks++;
      if (fb - rb < 119000 || fb - rb > 121500 || fb < 0) begin
         n_fail++; $display("FAIL sweep12_width: got %0d ns expected 119000..121500", fb - rb);
      end
      n_checks++;
      if (fc - rc < 119000 || fc - rc > 121500 || fc < 0) begin
         n_fail++; $display("FAIL sweep48_width: got %0d ns expected 119000..121500", fc - rc);
      end
      n_checks++;
      if (rb - rc > 1000 || rc - rb > 1000 || fb - fc > 1000 || fc - fb > 1000) begin
         n_fail++;
         $display("FAIL sweep_match: got 12M %0d/%0d 48M %0d/%0d ns expected within 1000", rb, fb, rc, fc);
      end
      n_checks++;
      if ({conv_b, conv_c} !== 2'b00) begin
         n_fail++; $display("FAIL sweep_conv: got %b expected 00", {conv_b, conv_c});
      end
      sw_en = 1'b0;
      rst_n_sw = 1'b0;
   endtask

   initial begin
      #60_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_skip_read();
      test_convert();
      test_unknown();
      test_mid_read();
      test_short_low();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ds18b20_responder.md
# ds18b20_responder

A 1-Wire slave that behaves like a single DS18B20 on the `ds18b20_dq` bus. It detects reset pulses, answers with a presence pulse, and accepts Skip ROM, Convert T and Read Scratchpad. Scratchpad bytes are returned with a correct Dallas CRC8. It is the bus-side counterpart of the DS18B20 master inside `tt_um_top`: simulation and on-board loopback use it in place of a real sensor. Open-drain is resolved at the top: `dq_oe=1` pulls the bus low.

## Interface
- `CLK_HZ`, 12_000_000: clock frequency; one µs tick = CLK_HZ/1_000_000 cycles (integer, ≥ 2).
- `clk`  input  1  system clock, all logic on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `dq_in`  input  1  sampled bus level (asynchronous, external pull-up).
- `temp_in`  input  16  two's-complement temperature, 1/16 °C LSB, latched on Convert T.
- `dq_oe`  output  1  1 = drive bus low; 0 = release.
- `conv_pulse`  output  1  one-cycle pulse when `temp_in` is latched.

## Operation
- `dq_in` passes through a 2-flop synchronizer. Falling and rising edges are detected on the synchronized value.
- A µs prescaler plus a slot counter of ≥ 10 bits measures all times.
- States:
  - IDLE: no activity.
  - RST_WAIT: bus low, measuring its duration.
  - PRES_DLY: 30 µs after the reset pulse is released.
  - PRESENCE: drive low for 120 µs.
  - ROM_CMD: receive 8 bits.
  - FN_CMD: receive 8 bits.
  - TX_SCRATCH: 72 read slots.
  - CONV_RD: read slots after Convert T.
  - HALT: ignore until reset.
- Reset detection has priority in every state. A synchronized low lasting ≥ 480 µs is a reset pulse, even mid-byte or mid-read. On its rising edge the block goes to PRES_DLY, and the bit/byte counters and shift register are cleared.
- Write slot (ROM_CMD, FN_CMD): at a falling edge, sample the synchronized line 30 µs later. High = 1, low = 0. Bits are shifted LSB first; after 8 bits the byte is decoded.
- ROM_CMD byte: 0xCC → FN_CMD. Any other value → HALT.
- FN_CMD byte:
  - 0x44 → latch `temp_in` into scratchpad bytes 0 (LSB) and 1 (MSB), pulse `conv_pulse`, go to CONV_RD.
  - 0xBE → TX_SCRATCH.
  - Any other value → HALT.
- Read slot (TX_SCRATCH): on the falling edge, if the current bit is 0, assert `dq_oe` for 30 µs, then release. If it is 1, never drive. Advance one bit per slot, LSB first.
- Scratchpad byte order:
  - 0–1: temperature.
  - 2: 0x4B.
  - 3: 0x46.
  - 4: 0x7F.
  - 5: 0xFF.
  - 6: 0x0C.
  - 7: 0x10.
  - 8: CRC8.
- CRC8: polynomial x^8+x^5+x^4+1, reflected 0x8C, init 0x00, over bytes 0–7. It is computed serially as bits are sent and emitted as byte 8.
- After bit 71 → HALT. Additional read slots return 1.
- CONV_RD: read slots return 1 (conversion is instantaneous). Write slots are ignored.
- Temperature register reset value: 0x0550 (85 °C).

## Timing
- Reset values: `dq_oe=0`, `conv_pulse=0`, state IDLE, temperature 0x0550, counters 0.
- Edge-detect latency: 2–3 cycles after a `dq_in` change. All µs intervals are measured from the detected edge, with ±1 tick tolerance.
- Presence: `dq_oe` rises 30 µs after the reset pulse is released and stays high for 120 µs.
- `conv_pulse` is high for exactly one cycle, in the cycle after the 8th bit of 0x44 is sampled. The temperature register updates in the same cycle.
- Read-slot `dq_oe` rises within 3 cycles of the master falling edge.
- Reset (`rst_n` low) during PRESENCE or a read-0 slot releases `dq_oe` immediately (asynchronously).
- A low shorter than 480 µs while in IDLE or HALT is ignored.
- A master that holds its own low past 30 µs does not stretch the responder drive.

## Test plan
- Reset then Skip ROM: 480 µs low, then release → `dq_oe` high at 30 µs for 120 µs. Send 0xCC, 0xBE, 72 read slots → 50 05 4B 46 7F FF 0C 10 1C.
- Convert then read: `temp_in`=0xFF5E; reset, 0xCC, 0x44 → one `conv_pulse`; read slots return 1. Reset, 0xCC, 0xBE → bytes 0–1 are 5E FF; CRC byte equals the bench-model CRC8 over bytes 0–7.
- Unknown command: reset, then 0x55 → HALT. Following read slots never drive `dq_oe`; the next reset still produces presence.
- Reset mid-read: after 20 read bits, a 500 µs low → presence. The new 0xCC/0xBE sequence restarts at byte 0.
- Short lows: 300 µs low in IDLE → no presence. `rst_n` asserted during presence → `dq_oe`=0 immediately.
- Parameter sweep: CLK_HZ = 12 MHz and 48 MHz → identical bus waveforms within ±1 µs.
